tach_if_mc: RTL and testbench
=============================

// Module: tach_if_mc
// PURPOSE
//  Multi-channel tachometer capture; parametrised successor to the single-channel tach interface.
//  Measures the period between selected edges of NUM_CH fan tach inputs, in tach_cnt_clk strobes.
//  Adds a per-channel glitch filter, a sticky overflow flag and a configurable counter width.
//  Sits between the PWM prescaler strobe and the APB register block.
// PARAMETERS
//  NUM_CH     4   number of independent tach channels (1..16)
//  CNT_WIDTH  16  period counter / result width in bits (8..32)
//  FILT_LEN   3   consecutive equal samples required to accept a level change (1..8)
// PORTS
//  PCLK          in   1                 system clock
//  PRESET        in   1                 asynchronous reset, active-high
//  tach_cnt_clk  in   1                 one-PCLK sample/count strobe from the prescaler
//  TACHIN        in   NUM_CH            raw tach inputs, asynchronous
//  TACHMODE      in   NUM_CH            per channel: 0 = continuous update, 1 = one-shot (hold until cleared)
//  TACH_EDGE     in   NUM_CH            per channel: 1 = measure rising-to-rising, 0 = falling-to-falling
//  status_clear  in   NUM_CH            per-channel one-PCLK clear pulse from an APB write; not strobe-gated
//  TACHPULSEDUR  out  NUM_CH*CNT_WIDTH  captured period; channel n is at [n*CNT_WIDTH +: CNT_WIDTH]
//  update_status out  NUM_CH            sticky "new result" flag
//  tach_ovf      out  NUM_CH            sticky "period exceeded counter range" flag
// BEHAVIOUR
//  Reset: every output is 0; sync, filter and counter registers are 0; all FSMs are in IDLE.
//   PRESET mid-measurement aborts that measurement with no capture.
//  Strobe gating: all sampling, filtering, counting and capture advance only on PCLK edges with tach_cnt_clk = 1.
//  Input path, per channel, on each strobe:
//   - 2-flop synchroniser.
//   - Shift register of the last FILT_LEN synchronised samples.
//   - Filtered level flt toggles only when all FILT_LEN samples equal !flt.
//   - Edge = selected transition of flt, per TACH_EDGE.
//   - A clean input level change produces an edge FILT_LEN+2 strobes after it is first sampled.
//  FSM per channel:
//   - IDLE -> ARMED on the first edge: cnt <= 0.
//   - ARMED, on each non-edge strobe: cnt <= cnt+1, saturating at 2^CNT_WIDTH-1. On first reaching saturation, set ovf_pend.
//   - ARMED, on an edge: result = ovf_pend ? 0 : cnt+1 (strobes between edges). Then cnt <= 0, ovf_pend <= 0, stay in ARMED.
//  Capture rules (applied at the edge):
//   - TACHMODE=0: TACHPULSEDUR and update_status <= 1 are updated on every edge.
//   - TACHMODE=1: update only when update_status = 0. Later edges are measured but discarded while the flag is set.
//   - ovf_pend at the edge also sets tach_ovf <= 1.
//  Output timing: TACHPULSEDUR and the flags are registered. They are visible on the PCLK cycle after the edge strobe.
//  status_clear[n]: clears update_status[n] and tach_ovf[n] on the next PCLK, whether or not a strobe is present.
//   TACHPULSEDUR is unaffected.
//  Simultaneous capture and status_clear on the same PCLK: the capture wins; the flags end up 1.
//  TACHMODE/TACH_EDGE changes:
//   - Take effect at the next strobe.
//   - A TACH_EDGE change forces the channel to IDLE, with no capture.
//  Channels are fully independent; no shared state except PCLK, PRESET and tach_cnt_clk.
// TESTING  (NUM_CH=4, CNT_WIDTH=16, FILT_LEN=3, tach_cnt_clk=1 every PCLK unless stated)
//  1. ch0 rising, mode 0, square wave period 100 PCLK.
//     -> ch0 TACHPULSEDUR=100 after the 2nd rising edge; update_status[0]=1; re-captured each period.
//  2. ch1 mode 1, periods 80 then 120, no clear.
//     -> holds 80; pulse status_clear[1]; next edge captures 120 and update_status[1] returns to 1.
//  3. ch2 low with a 2-PCLK high glitch.
//     -> no edge, no capture; a 3-PCLK high pulse is accepted, edge FILT_LEN+2=5 strobes after onset.
//  4. Rebuild with CNT_WIDTH=8; ch3 period 300.
//     -> captured value 0, tach_ovf[3]=1; a following period of 200 captures 200 with tach_ovf still 1 until cleared.
//  5. Strobe every 4th PCLK, ch0 period 400 PCLK.
//     -> captures 100; status_clear and capture in the same PCLK leave update_status=1.
//  6. Assert PRESET mid-period on all channels.
//     -> all outputs 0 immediately; the first post-reset edge only arms, and the second edge yields a correct period.

Source files
------------

// File: rtl/tach_if_mc_if.sv
// Bundles the strobe, tach inputs, per-channel controls and captured results of tach_if_mc.
// The master drives strobe/inputs/controls; the slave (tach_if_mc) returns periods and flags.
interface tach_if_mc_if #(
   parameter int NUM_CH    = 4,
   parameter int CNT_WIDTH = 16
);
   logic                        tach_cnt_clk;
   logic [NUM_CH-1:0]           TACHIN;
   logic [NUM_CH-1:0]           TACHMODE;
   logic [NUM_CH-1:0]           TACH_EDGE;
   logic [NUM_CH-1:0]           status_clear;
   logic [NUM_CH*CNT_WIDTH-1:0] TACHPULSEDUR;
   logic [NUM_CH-1:0]           update_status;
   logic [NUM_CH-1:0]           tach_ovf;

   modport master (
      output tach_cnt_clk, TACHIN, TACHMODE, TACH_EDGE, status_clear,
      input  TACHPULSEDUR, update_status, tach_ovf
   );

   modport slave (
      input  tach_cnt_clk, TACHIN, TACHMODE, TACH_EDGE, status_clear,
      output TACHPULSEDUR, update_status, tach_ovf
   );
endinterface

// File: rtl/tach_if_mc.sv
// Multi-channel tachometer capture: per-channel synchroniser, glitch filter and edge-to-edge
// period counter advancing on the prescaler strobe, with sticky result and overflow flags.
module tach_if_mc #(
   parameter int NUM_CH    = 4,
   parameter int CNT_WIDTH = 16,
   parameter int FILT_LEN  = 3
) (
   input logic         PCLK,
   input logic         PRESET,
   tach_if_mc_if.slave bus
);
   typedef enum logic {IDLE, ARMED} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Strobes between edges is one more than the counted non-edge strobes; overflow reports 0.
   function automatic logic [CNT_WIDTH-1:0] period_result(input logic [CNT_WIDTH-1:0] v,
                                                          input logic                 ovf);
      return ovf ? '0 : v + 1'b1;
   endfunction

   logic                 stb;
   logic [CNT_WIDTH-1:0] dur_all [NUM_CH];
   logic [NUM_CH-1:0]    upd_all;
   logic [NUM_CH-1:0]    ovf_all;

   assign stb = bus.tach_cnt_clk;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic                 sync_p0;
      logic                 sync_p1;
      logic [FILT_LEN-1:0]  shr_p2;
      logic                 flt;
      logic                 edge_q;
      state_t               state;
      logic [CNT_WIDTH-1:0] cnt;
      logic                 ovf_pend;
      logic [CNT_WIDTH-1:0] dur_q;
      logic                 upd_q;
      logic                 ovf_q;

      logic flip;
      logic sel_chg;
      logic edge_det;
      logic armed_edge;
      logic capture;
      logic ovf_set;

      always_comb begin
         flip       = stb && (shr_p2 == {FILT_LEN{~flt}});
         sel_chg    = stb && (bus.TACH_EDGE[n] != edge_q);
         edge_det   = flip && !sel_chg && ((~flt) == bus.TACH_EDGE[n]);
         armed_edge = edge_det && (state == ARMED);
         capture    = armed_edge && (!bus.TACHMODE[n] || !upd_q);
         ovf_set    = armed_edge && ovf_pend;
      end

      always_ff @(posedge PCLK or posedge PRESET) begin
         if (PRESET) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            shr_p2   <= '0;
            flt      <= 1'b0;
            edge_q   <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            dur_q    <= '0;
            upd_q    <= 1'b0;
            ovf_q    <= 1'b0;
         end else begin
            if (stb) begin
               // p0/p1: metastability synchroniser, p2: filter history window
               sync_p0 <= bus.TACHIN[n];
               sync_p1 <= sync_p0;
               shr_p2  <= FILT_LEN'({shr_p2, sync_p1});
               if (flip)
                  flt <= ~flt;
               edge_q <= bus.TACH_EDGE[n];

               if (sel_chg) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  ovf_pend <= 1'b0;
               end else begin
                  case (state)
                     IDLE: begin
                        if (edge_det) begin
                           state    <= ARMED;
                           cnt      <= '0;
                           ovf_pend <= 1'b0;
                        end
                     end
                     ARMED: begin
                        if (edge_det) begin
                           cnt      <= '0;
                           ovf_pend <= 1'b0;
                        end else begin
                           cnt <= sat_inc(cnt);
                           if (sat_inc(cnt) == CNT_MAX)
                              ovf_pend <= 1'b1;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end

            // Result stage: a capture outranks a simultaneous clear so no result is lost.
            if (capture) begin
               dur_q <= period_result(cnt, ovf_pend);
               upd_q <= 1'b1;
            end else if (bus.status_clear[n]) begin
               upd_q <= 1'b0;
            end

            if (ovf_set)
               ovf_q <= 1'b1;
            else if (bus.status_clear[n])
               ovf_q <= 1'b0;
         end
      end

      assign dur_all[n] = dur_q;
      assign upd_all[n] = upd_q;
      assign ovf_all[n] = ovf_q;
   end

   always_comb begin
      bus.TACHPULSEDUR = '0;
      for (int i = 0; i < NUM_CH; i++)
         bus.TACHPULSEDUR[i*CNT_WIDTH +: CNT_WIDTH] = dur_all[i];
   end

   assign bus.update_status = upd_all;
   assign bus.tach_ovf      = ovf_all;
endmodule

// File: tb/tb_tach_if_mc.sv
// Bench for tach_if_mc: a 16-bit and an 8-bit instance share one directed stimulus stream
// and are compared each cycle against a period-arithmetic model, plus pinned literal values.
module tb_tach_if_mc;
   localparam int NCH = 4;
   localparam int FL  = 3;

   logic PCLK = 1'b0;
   logic PRESET;

   logic       stb;
   logic [3:0] tin, mode, esel, sclr;

   tach_if_mc_if #(.NUM_CH(NCH), .CNT_WIDTH(16)) bus16 ();
   tach_if_mc_if #(.NUM_CH(NCH), .CNT_WIDTH(8))  bus8 ();

   assign bus16.tach_cnt_clk = stb;
   assign bus16.TACHIN       = tin;
   assign bus16.TACHMODE     = mode;
   assign bus16.TACH_EDGE    = esel;
   assign bus16.status_clear = sclr;
   assign bus8.tach_cnt_clk  = stb;
   assign bus8.TACHIN        = tin;
   assign bus8.TACHMODE      = mode;
   assign bus8.TACH_EDGE     = esel;
   assign bus8.status_clear  = sclr;

   tach_if_mc #(.NUM_CH(NCH), .CNT_WIDTH(16), .FILT_LEN(FL)) dut16 (
      .PCLK(PCLK), .PRESET(PRESET), .bus(bus16));
   tach_if_mc #(.NUM_CH(NCH), .CNT_WIDTH(8), .FILT_LEN(FL)) dut8 (
      .PCLK(PCLK), .PRESET(PRESET), .bus(bus8));

   always #5 PCLK = ~PCLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
      end
   endtask

   // ---------------- model: periods as differences of strobe indices ----------------
   logic [3:0]  hist[$];
   int          sidx;
   bit          flt_m[NCH];
   bit          eq_m[NCH];
   bit          arm_m[NCH];
   int          arm_s[NCH];
   logic [15:0] e_dur[2][NCH];
   bit          e_upd[2][NCH];
   bit          e_ovf[2][NCH];

   task automatic model_reset();
      hist.delete();
      repeat (FL + 3) hist.push_back(4'b0000);
      sidx = 0;
      for (int c = 0; c < NCH; c++) begin
         flt_m[c] = 0; eq_m[c] = 0; arm_m[c] = 0; arm_s[c] = 0;
         for (int i = 0; i < 2; i++) begin
            e_dur[i][c] = '0; e_upd[i][c] = 0; e_ovf[i][c] = 0;
         end
      end
   endtask

   task automatic model_step();
      bit all_new;
      int per;
      int lim;
      bit ov;
      bit su[2];
      bit so[2];
      if (stb) begin
         sidx++;
         hist.push_back(tin);
         if (hist.size() > FL + 3) void'(hist.pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
         su[0] = 0; su[1] = 0; so[0] = 0; so[1] = 0;
         if (stb) begin
            // level change accepted once samples taken 3..FL+2 strobes ago all differ from flt
            all_new = 1;
            for (int k = 3; k <= FL + 2; k++)
               if (hist[hist.size()-1-k][c] == flt_m[c]) all_new = 0;
            if (all_new) flt_m[c] = !flt_m[c];
            if (esel[c] != eq_m[c]) begin
               eq_m[c]  = esel[c];
               arm_m[c] = 0;
            end else if (all_new && (flt_m[c] == esel[c])) begin
               if (!arm_m[c]) begin
                  arm_m[c] = 1;
                  arm_s[c] = sidx;
               end else begin
                  per      = sidx - arm_s[c];
                  arm_s[c] = sidx;
                  for (int i = 0; i < 2; i++) begin
                     lim = (i == 0) ? 65536 : 256;
                     ov  = (per >= lim);
                     if (!mode[c] || !e_upd[i][c]) begin
                        e_dur[i][c] = ov ? 16'd0 : 16'(per);
                        su[i] = 1;
                     end
                     if (ov) so[i] = 1;
                  end
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (su[i]) e_upd[i][c] = 1;
            else if (sclr[c]) e_upd[i][c] = 0;
            if (so[i]) e_ovf[i][c] = 1;
            else if (sclr[c]) e_ovf[i][c] = 0;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge PCLK or posedge PRESET);
         if (PRESET) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [63:0] ed16, ed8;
      logic [3:0]  eu16, eu8, eo16, eo8;
      forever begin
         @(negedge PCLK);
         ed16 = '0; ed8 = '0;
         for (int c = 0; c < NCH; c++) begin
            ed16[c*16 +: 16] = e_dur[0][c];
            ed8[c*8 +: 8]    = e_dur[1][c][7:0];
            eu16[c] = e_upd[0][c]; eu8[c] = e_upd[1][c];
            eo16[c] = e_ovf[0][c]; eo8[c] = e_ovf[1][c];
         end
         chk("dur16", bus16.TACHPULSEDUR, ed16);
         chk("upd16", bus16.update_status, eu16);
         chk("ovf16", bus16.tach_ovf, eo16);
         chk("dur8", bus8.TACHPULSEDUR, ed8);
         chk("upd8", bus8.update_status, eu8);
         chk("ovf8", bus8.tach_ovf, eo8);
      end
   end

   // ---------------- stimulus ----------------
   int sdiv, pc;
   bit gen[NCH];
   int hi_n[NCH], lo_n[NCH], hi_c[NCH], lo_c[NCH], ph[NCH];

   task automatic cyc(input int n);
      repeat (n) begin
         for (int c = 0; c < NCH; c++) begin
            if (gen[c]) begin
               if (ph[c] == 0) begin
                  hi_c[c] = hi_n[c];
                  lo_c[c] = lo_n[c];
               end
               tin[c] = (ph[c] < hi_c[c]);
               ph[c]++;
               if (ph[c] >= hi_c[c] + lo_c[c]) ph[c] = 0;
            end
         end
         stb = (pc % sdiv == 0);
         pc++;
         @(posedge PCLK);
         #2;
         sclr = '0;
      end
   endtask

   task automatic start_gen(input int c, input int hi, input int lo);
      hi_n[c] = hi; lo_n[c] = lo; ph[c] = 0; gen[c] = 1;
   endtask

   initial begin
      PRESET = 1'b1;
      stb = 1'b0; tin = '0; mode = '0; sclr = '0;
      esel = 4'b0111;
      sdiv = 1; pc = 0;
      for (int c = 0; c < NCH; c++) begin
         gen[c] = 0; hi_n[c] = 1; lo_n[c] = 1; hi_c[c] = 1; lo_c[c] = 1; ph[c] = 0;
      end
      cyc(3);
      chk("rst_dur16", bus16.TACHPULSEDUR, 64'd0);
      chk("rst_upd16", bus16.update_status, 64'd0);
      chk("rst_ovf8", bus8.tach_ovf, 64'd0);
      PRESET = 1'b0;

      // ch0 rising, continuous, period 100
      start_gen(0, 50, 50);
      cyc(350);
      chk("t1_dur16_ch0", bus16.TACHPULSEDUR[15:0], 64'd100);
      chk("t1_dur8_ch0", bus8.TACHPULSEDUR[7:0], 64'd100);
      chk("t1_upd_ch0", bus16.update_status[0], 64'd1);
      chk("t1_model_ch0", e_dur[0][0], 64'd100);
      gen[0] = 0; tin[0] = 1'b0;

      // ch1 one-shot: 80 held while 120 arrives, clear, then 120 captured
      mode[1] = 1'b1;
      start_gen(1, 40, 40);
      cyc(150);
      hi_n[1] = 60; lo_n[1] = 60;
      cyc(150);
      chk("t2_hold_ch1", bus16.TACHPULSEDUR[31:16], 64'd80);
      chk("t2_upd_ch1", bus16.update_status[1], 64'd1);
      sclr[1] = 1'b1;
      cyc(1);
      chk("t2_clr_ch1", bus16.update_status[1], 64'd0);
      cyc(110);
      chk("t2_new_ch1", bus16.TACHPULSEDUR[31:16], 64'd120);
      chk("t2_upd2_ch1", bus16.update_status[1], 64'd1);
      gen[1] = 0; tin[1] = 1'b0;

      // ch2 glitch filter: 2-PCLK glitches rejected, 3-PCLK pulses 30 apart accepted
      tin[2] = 1'b1; cyc(2);
      tin[2] = 1'b0; cyc(20);
      tin[2] = 1'b1; cyc(3);
      tin[2] = 1'b0; cyc(7);
      tin[2] = 1'b1; cyc(2);
      tin[2] = 1'b0; cyc(18);
      tin[2] = 1'b1; cyc(3);
      tin[2] = 1'b0; cyc(2);
      chk("t3_before_edge", bus16.update_status[2], 64'd0);
      cyc(1);
      chk("t3_at_edge", bus16.update_status[2], 64'd1);
      chk("t3_dur_ch2", bus16.TACHPULSEDUR[47:32], 64'd30);
      cyc(10);

      // ch3 falling, period 300 (overflows 8 bits) then 200
      start_gen(3, 50, 250);
      cyc(700);
      chk("t4_dur8_ovf", bus8.TACHPULSEDUR[31:24], 64'd0);
      chk("t4_ovf8", bus8.tach_ovf[3], 64'd1);
      chk("t4_dur16", bus16.TACHPULSEDUR[63:48], 64'd300);
      lo_n[3] = 150;
      cyc(460);
      chk("t4_dur8_200", bus8.TACHPULSEDUR[31:24], 64'd200);
      chk("t4_ovf8_sticky", bus8.tach_ovf[3], 64'd1);
      chk("t4_ovf16", bus16.tach_ovf[3], 64'd0);
      sclr[3] = 1'b1;
      cyc(1);
      chk("t4_ovf8_clr", bus8.tach_ovf[3], 64'd0);
      chk("t4_dur8_kept", bus8.TACHPULSEDUR[31:24], 64'd200);
      gen[3] = 0;

      // ch0 with strobe every 4th PCLK, period 400 PCLK; clear coincides with capture
      sdiv = 4; pc = 0;
      start_gen(0, 200, 200);
      cyc(300);
      sclr[0] = 1'b1;
      cyc(1);
      chk("t5_cleared", bus16.update_status[0], 64'd0);
      cyc(119);
      sclr[0] = 1'b1;
      cyc(1);
      chk("t5_clr_vs_cap", bus16.update_status[0], 64'd1);
      chk("t5_dur16", bus16.TACHPULSEDUR[15:0], 64'd100);
      chk("t5_dur8", bus8.TACHPULSEDUR[7:0], 64'd100);
      gen[0] = 0; tin[0] = 1'b0;
      sdiv = 1;
      cyc(10);

      // reset mid-period on all channels
      mode = '0;
      start_gen(0, 50, 50);
      start_gen(1, 60, 60);
      start_gen(2, 35, 35);
      start_gen(3, 50, 50);
      cyc(150);
      PRESET = 1'b1;
      #1;
      chk("t6_rst_dur16", bus16.TACHPULSEDUR, 64'd0);
      chk("t6_rst_upd16", bus16.update_status, 64'd0);
      chk("t6_rst_ovf16", bus16.tach_ovf, 64'd0);
      chk("t6_rst_dur8", bus8.TACHPULSEDUR, 64'd0);
      chk("t6_rst_ovf8", bus8.tach_ovf, 64'd0);
      #1;
      cyc(2);
      PRESET = 1'b0;
      cyc(300);
      chk("t6_ch0", bus16.TACHPULSEDUR[15:0], 64'd100);
      chk("t6_ch1", bus16.TACHPULSEDUR[31:16], 64'd120);
      chk("t6_ch2", bus16.TACHPULSEDUR[47:32], 64'd70);
      chk("t6_ch3", bus16.TACHPULSEDUR[63:48], 64'd100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
